// File: rtl/ecc_scrub_scheduler.sv
// Trigger-rate scheduler, correction statistics and nominal address mirror for the ECC scrubber.
// Optional macro ECC_SCRUB_SCHED_ADAPTIVE_EN halves the scrub period while the current pass has seen corrections.
module ecc_scrub_scheduler #(
  parameter int BankSize      = 256,
  parameter int IntervalWidth = 16,
  parameter int CntWidth      = 16,
  parameter int MinInterval   = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         enable_i,
  input  logic [IntervalWidth-1:0]     interval_i,
  input  logic [CntWidth-1:0]          threshold_i,
  input  logic                         clear_i,
  input  logic                         irq_clr_i,
  input  logic                         bit_corrected_i,
  output logic                         scrub_trigger_o,
  output logic                         pass_done_o,
  output logic [$clog2(BankSize)-1:0]  scrub_addr_o,
  output logic [CntWidth-1:0]          corr_count_o,
  output logic [CntWidth-1:0]          pass_count_o,
  output logic                         irq_o
);

  localparam int AddrWidth = $clog2(BankSize);
  localparam logic [AddrWidth-1:0]     LastAddr = AddrWidth'(BankSize - 1);
  localparam logic [IntervalWidth-1:0] MinIntv  = IntervalWidth'(MinInterval);
  localparam logic [CntWidth-1:0]      CntMax   = '1;

  typedef enum logic {StOff, StCount} state_e;

  state_e                   state_q;
  logic [IntervalWidth-1:0] timer_q;
  logic [AddrWidth-1:0]     addr_q;
  logic                     pass_done_q;
  logic [CntWidth-1:0]      corr_q;
  logic [CntWidth-1:0]      pass_q;
  logic                     irq_q;

  logic [IntervalWidth-1:0] req_interval;
  logic [IntervalWidth-1:0] eff_interval;
  logic [IntervalWidth-1:0] eff_last;
  logic                     timer_hit;
  logic                     trigger;
  logic                     wrap;
  logic                     corr_inc;
  logic [CntWidth-1:0]      corr_d;
  logic                     irq_set;

`ifdef ECC_SCRUB_SCHED_ADAPTIVE_EN
  // Only "any correction this pass" matters, so a single flag stands in for the per-pass count.
  logic pass_err_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pass_err_q <= 1'b0;
    end else if (clear_i || wrap) begin
      pass_err_q <= 1'b0;
    end else if (bit_corrected_i) begin
      pass_err_q <= 1'b1;
    end
  end

  assign req_interval = pass_err_q ? (interval_i >> 1) : interval_i;
`else
  assign req_interval = interval_i;
`endif

  assign eff_interval = (req_interval < MinIntv) ? MinIntv : req_interval;
  assign eff_last     = eff_interval - IntervalWidth'(1);
  assign timer_hit    = (timer_q >= eff_last);
  assign trigger      = (state_q == StCount) && enable_i && timer_hit;
  assign wrap         = trigger && (addr_q == LastAddr);

  // Only an actual increment can raise irq, so a parked count or saturation never re-arms it.
  assign corr_inc = bit_corrected_i && (corr_q != CntMax);
  assign corr_d   = corr_inc ? corr_q + CntWidth'(1) : corr_q;
  assign irq_set  = corr_inc && (corr_d == threshold_i) && (threshold_i != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StOff;
      timer_q <= '0;
    end else begin
      case (state_q)
        StOff: begin
          timer_q <= '0;
          if (enable_i) state_q <= StCount;
        end
        StCount: begin
          if (!enable_i) begin
            state_q <= StOff;
            timer_q <= '0;
          end else if (timer_hit) begin
            timer_q <= '0;
          end else begin
            timer_q <= timer_q + IntervalWidth'(1);
          end
        end
        default: begin
          state_q <= StOff;
          timer_q <= '0;
        end
      endcase
    end
  end

  // clear_i takes priority over any coincident correction, wrap or irq set.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q      <= '0;
      pass_done_q <= 1'b0;
      corr_q      <= '0;
      pass_q      <= '0;
      irq_q       <= 1'b0;
    end else if (clear_i) begin
      addr_q      <= '0;
      pass_done_q <= 1'b0;
      corr_q      <= '0;
      pass_q      <= '0;
      irq_q       <= 1'b0;
    end else begin
      pass_done_q <= wrap;
      corr_q      <= corr_d;
      if (trigger) addr_q <= wrap ? '0 : addr_q + AddrWidth'(1);
      if (wrap && (pass_q != CntMax)) pass_q <= pass_q + CntWidth'(1);
      if (irq_set) begin
        irq_q <= 1'b1;
      end else if (irq_clr_i) begin
        irq_q <= 1'b0;
      end
    end
  end

  assign scrub_trigger_o = trigger;
  assign pass_done_o     = pass_done_q;
  assign scrub_addr_o    = addr_q;
  assign corr_count_o    = corr_q;
  assign pass_count_o    = pass_q;
  assign irq_o           = irq_q;

endmodule

// File: tb/tb_ecc_scrub_scheduler.sv
// Scoreboard bench for ecc_scrub_scheduler: expected trigger cycles are queued as stimulus is driven.
module tb_ecc_scrub_scheduler;

  localparam int BankSize      = 4;
  localparam int IntervalWidth = 16;
  localparam int CntWidth      = 4;
  localparam int MinInterval   = 4;

  logic                     clk_i = 1'b0;
  logic                     rst_ni = 1'b0;
  logic                     enable_i = 1'b0;
  logic [IntervalWidth-1:0] interval_i = 16'd10;
  logic [CntWidth-1:0]      threshold_i = '0;
  logic                     clear_i = 1'b0;
  logic                     irq_clr_i = 1'b0;
  logic                     bit_corrected_i = 1'b0;
  logic                     scrub_trigger_o;
  logic                     pass_done_o;
  logic [1:0]               scrub_addr_o;
  logic [CntWidth-1:0]      corr_count_o;
  logic [CntWidth-1:0]      pass_count_o;
  logic                     irq_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];

  ecc_scrub_scheduler #(
    .BankSize(BankSize), .IntervalWidth(IntervalWidth),
    .CntWidth(CntWidth), .MinInterval(MinInterval)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .interval_i(interval_i),
    .threshold_i(threshold_i), .clear_i(clear_i), .irq_clr_i(irq_clr_i),
    .bit_corrected_i(bit_corrected_i), .scrub_trigger_o(scrub_trigger_o),
    .pass_done_o(pass_done_o), .scrub_addr_o(scrub_addr_o), .corr_count_o(corr_count_o),
    .pass_count_o(pass_count_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Every observed trigger pops the next expected trigger cycle.
  always @(negedge clk_i) begin : trigger_monitor
    int exp_c;
    if (scrub_trigger_o) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL trigger_unexpected: pulse at cycle %0d, expected no pulse", cyc);
      end else begin
        exp_c = exp_q.pop_front();
        if (cyc !== exp_c) begin
          errors++;
          $display("[TB] FAIL trigger_cycle: pulse at cycle %0d, expected cycle %0d", cyc, exp_c);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: time %0t, expected completion earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({scrub_trigger_o, pass_done_o, scrub_addr_o, corr_count_o, pass_count_o, irq_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b, expected 0",
               {scrub_trigger_o, pass_done_o, scrub_addr_o, corr_count_o, pass_count_o, irq_o});
    end
    step();
    step();
    rst_ni = 1'b1;
    step();
    checks++;
    if ({scrub_trigger_o, pass_done_o, scrub_addr_o, corr_count_o, pass_count_o, irq_o} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_release: got %b, expected 0",
               {scrub_trigger_o, pass_done_o, scrub_addr_o, corr_count_o, pass_count_o, irq_o});
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL %s_drained: %0d pulses missing, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_periodic();
    int c;
    interval_i = 16'd10;
    enable_i = 1'b1;
    c = cyc;
    for (int k = 1; k <= 3; k++) exp_q.push_back(c + 10 * k);
    repeat (31) step();
    interval_i = 16'd2;
    for (int k = 1; k <= 3; k++) exp_q.push_back(c + 30 + 4 * k);
    repeat (12) step();
    enable_i = 1'b0;
    repeat (3) step();
    check_drained("periodic");
  endtask

  task automatic test_address_wrap();
    int c;
    int n;
    clear_i = 1'b1;
    interval_i = 16'd5;
    enable_i = 1'b1;
    c = cyc;
    for (int k = 1; k <= 8; k++) exp_q.push_back(c + 5 * k);
    for (int k = 1; k <= 41; k++) begin
      step();
      clear_i = 1'b0;
      n = (k - 1) / 5;
      checks++;
      if (int'(scrub_addr_o) !== n % BankSize) begin
        errors++;
        $display("[TB] FAIL wrap_addr: got %0d, expected %0d at offset %0d", scrub_addr_o, n % BankSize, k);
      end
      checks++;
      if (int'(pass_count_o) !== n / BankSize) begin
        errors++;
        $display("[TB] FAIL wrap_pass_count: got %0d, expected %0d at offset %0d", pass_count_o, n / BankSize, k);
      end
      checks++;
      if (pass_done_o !== (k > 1 && (k - 1) % 20 == 0)) begin
        errors++;
        $display("[TB] FAIL wrap_pass_done: got %0d, expected %0d at offset %0d", pass_done_o,
                 (k > 1 && (k - 1) % 20 == 0), k);
      end
    end
    enable_i = 1'b0;
    repeat (3) step();
    check_drained("wrap");
  endtask

  task automatic test_irq();
    threshold_i = 4'd3;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bit_corrected_i = 1'b1;
      step();
      bit_corrected_i = 1'b0;
      checks++;
      if (irq_o !== (i == 3) || int'(corr_count_o) !== i) begin
        errors++;
        $display("[TB] FAIL irq_rise: got irq %0d count %0d, expected irq %0d count %0d", irq_o, corr_count_o, (i == 3), i);
      end
      step();
    end
    irq_clr_i = 1'b1;
    step();
    irq_clr_i = 1'b0;
    step();
    checks++;
    if (irq_o !== 1'b0) begin
      errors++;
      $display("[TB] FAIL irq_clear: got %0d, expected 0", irq_o);
    end
    bit_corrected_i = 1'b1;
    step();
    bit_corrected_i = 1'b0;
    checks++;
    if (irq_o !== 1'b0 || corr_count_o !== 4'd4) begin
      errors++;
      $display("[TB] FAIL irq_fourth: got irq %0d count %0d, expected irq 0 count 4", irq_o, corr_count_o);
    end
    clear_i = 1'b1;
    threshold_i = 4'd1;
    step();
    clear_i = 1'b0;
    bit_corrected_i = 1'b1;
    irq_clr_i = 1'b1;
    step();
    bit_corrected_i = 1'b0;
    irq_clr_i = 1'b0;
    checks++;
    if (irq_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL irq_set_wins: got %0d, expected 1", irq_o);
    end
    clear_i = 1'b1;
    threshold_i = 4'd0;
    step();
    clear_i = 1'b0;
    checks++;
    if (irq_o !== 1'b0 || corr_count_o !== 4'd0) begin
      errors++;
      $display("[TB] FAIL irq_clear_i: got irq %0d count %0d, expected irq 0 count 0", irq_o, corr_count_o);
    end
    bit_corrected_i = 1'b1;
    repeat (3) step();
    bit_corrected_i = 1'b0;
    checks++;
    if (irq_o !== 1'b0 || corr_count_o !== 4'd3) begin
      errors++;
      $display("[TB] FAIL irq_disabled: got irq %0d count %0d, expected irq 0 count 3", irq_o, corr_count_o);
    end
  endtask

  task automatic test_saturation();
    threshold_i = 4'd0;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    bit_corrected_i = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      step();
      checks++;
      if (int'(corr_count_o) !== ((i > 15) ? 15 : i)) begin
        errors++;
        $display("[TB] FAIL sat_count: got %0d, expected %0d", corr_count_o, (i > 15) ? 15 : i);
      end
    end
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    bit_corrected_i = 1'b0;
    checks++;
    if (corr_count_o !== 4'd0) begin
      errors++;
      $display("[TB] FAIL sat_clear_wins: got %0d, expected 0", corr_count_o);
    end
  endtask

  task automatic test_enable_changes();
    int c;
    int e;
    interval_i = 16'd10;
    enable_i = 1'b1;
    c = cyc;
    repeat (8) step();
    enable_i = 1'b0;
    repeat (4) step();
    enable_i = 1'b1;
    exp_q.push_back(c + 22);
    repeat (11) step();
    enable_i = 1'b0;
    repeat (2) step();
    interval_i = 16'd20;
    enable_i = 1'b1;
    e = cyc;
    repeat (13) step();
    interval_i = 16'd5;
    exp_q.push_back(e + 13);
    exp_q.push_back(e + 18);
    repeat (6) step();
    enable_i = 1'b0;
    repeat (3) step();
    check_drained("enable");
  endtask

  task automatic test_adaptive();
    int c;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    interval_i = 16'd20;
    bit_corrected_i = 1'b1;
    enable_i = 1'b1;
    c = cyc;
`ifdef ECC_SCRUB_SCHED_ADAPTIVE_EN
    exp_q.push_back(c + 10);
    exp_q.push_back(c + 20);
`else
    exp_q.push_back(c + 20);
`endif
    step();
    bit_corrected_i = 1'b0;
    repeat (20) step();
    enable_i = 1'b0;
    repeat (3) step();
    check_drained("adaptive");
  endtask

  task automatic test_midop_reset();
    int c;
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    threshold_i = 4'd2;
    interval_i = 16'd10;
    enable_i = 1'b1;
    c = cyc;
    exp_q.push_back(c + 10);
    bit_corrected_i = 1'b1;
    repeat (3) step();
    bit_corrected_i = 1'b0;
    repeat (10) step();
    checks++;
    if (scrub_addr_o !== 2'd1 || corr_count_o !== 4'd3 || irq_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL midop_pre: got addr %0d count %0d irq %0d, expected addr 1 count 3 irq 1",
               scrub_addr_o, corr_count_o, irq_o);
    end
    #3;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({scrub_trigger_o, pass_done_o, scrub_addr_o, corr_count_o, pass_count_o, irq_o} !== '0) begin
      errors++;
      $display("[TB] FAIL midop_reset: got %b, expected 0",
               {scrub_trigger_o, pass_done_o, scrub_addr_o, corr_count_o, pass_count_o, irq_o});
    end
    enable_i = 1'b0;
    step();
    rst_ni = 1'b1;
    repeat (2) step();
    check_drained("midop");
  endtask

  initial begin
    test_reset();
    test_periodic();
    test_address_wrap();
    test_irq();
    test_saturation();
    test_enable_changes();
    test_adaptive();
    test_midop_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
